game_countdown_timer: RTL and testbench

- Downstream consumer of the flexible clock divider's `slow_clk` output.
- Divider is configured for a 1 Hz toggle (m = 49_999_999 at 100 MHz); this block turns each rising edge of `slow_clk` into a one-second tick.
- Implements the flow-game round timer: loadable 0–99 s BCD countdown with start/pause, expiry pulse and time-up level.
- Outputs drive the 7-segment display driver and the game-control FSM.

---
 rtl/timer_pkg.sv | 55 +++++
 rtl/rise_edge_detect.sv | 31 +++
 rtl/game_countdown_timer.sv | 129 ++++++++++++
 tb/tb_game_countdown_timer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg : shared types, constants and BCD helpers for the          |
// |             game countdown timer.                                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam int MAX_SECONDS     = 99;
  localparam int DEFAULT_SECONDS = 60;

  // Compare/subtract-10 chain; input must already be clamped to 0..99.
  function automatic bcd2_t bin_to_bcd99(input logic [6:0] bin);
    logic [6:0] rem;
    bcd2_t      res;
    rem      = bin;
    res.tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem      = rem - 7'd10;
        res.tens = res.tens + 4'd1;
      end
    end
    res.ones = 4'(rem);
    return res;
  endfunction

  function automatic bcd2_t bcd_decrement(input bcd2_t v);
    bcd2_t res;
    if (v.ones != 4'd0) begin
      res.tens = v.tens;
      res.ones = v.ones - 4'd1;
    end else begin
      res.ones = 4'd9;
      res.tens = (v.tens != 4'd0) ? v.tens - 4'd1 : 4'd0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rise_edge_detect : one-cycle pulse on a rising edge of a level that  |
// |                    is sampled as data in the basys_clk domain.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rise_edge_detect #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic basys_clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  // History resets to the expected idle level of the input so that the
  // first cycle after reset never reports a spurious edge.
  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RESET_VALUE;
    end else begin
      prev_q <= in;
    end
  end

  assign pulse = in & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/game_countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_countdown_timer : loadable 0-99 s BCD round timer driven by the |
// |                        1 Hz slow_clk, with start/pause and expiry.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module game_countdown_timer #(
  parameter int MAX_SECONDS     = timer_pkg::MAX_SECONDS,
  parameter int DEFAULT_SECONDS = timer_pkg::DEFAULT_SECONDS
) (
  input  logic       basys_clk,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       load,
  input  logic [6:0] load_value,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       time_up
);

  import timer_pkg::*;

  localparam bcd2_t RESET_BCD = '{tens: 4'(DEFAULT_SECONDS / 10),
                                  ones: 4'(DEFAULT_SECONDS % 10)};

  state_e     state_q;
  bcd2_t      digits_q;
  logic       running_q;
  logic       expired_q;
  logic       time_up_q;

  logic       tick;
  logic [6:0] load_clamped;
  bcd2_t      load_bcd;
  logic       count_zero;
  logic       count_last;

  rise_edge_detect #(
    .RESET_VALUE (1'b1)
  ) u_slow_edge (
    .basys_clk (basys_clk),
    .rst_n     (rst_n),
    .in        (slow_clk),
    .pulse     (tick)
  );

  assign load_clamped = (load_value > 7'(MAX_SECONDS)) ? 7'(MAX_SECONDS) : load_value;
  assign load_bcd     = bin_to_bcd99(load_clamped);

  assign count_zero = (digits_q.tens == 4'd0) && (digits_q.ones == 4'd0);
  // 01 and the unreachable 00-in-RUN both land in DONE, so the count never wraps.
  assign count_last = (digits_q.tens == 4'd0) && (digits_q.ones <= 4'd1);

  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      digits_q  <= RESET_BCD;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (load) begin
        digits_q  <= load_bcd;
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        time_up_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (count_zero) begin
                state_q   <= ST_DONE;
                time_up_q <= 1'b1;
                expired_q <= 1'b1;
              end else begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            // A tick coinciding with pause is intentionally dropped.
            if (pause) begin
              state_q   <= ST_PAUSED;
              running_q <= 1'b0;
            end else if (tick) begin
              if (count_last) begin
                digits_q  <= '0;
                state_q   <= ST_DONE;
                running_q <= 1'b0;
                time_up_q <= 1'b1;
                expired_q <= 1'b1;
              end else begin
                digits_q  <= bcd_decrement(digits_q);
              end
            end
          end
          ST_PAUSED: begin
            if (start) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_DONE: begin
            digits_q <= '0;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tens    = digits_q.tens;
  assign ones    = digits_q.ones;
  assign running = running_q;
  assign expired = expired_q;
  assign time_up = time_up_q;

endmodule
`default_nettype wire

// File: tb/tb_game_countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_game_countdown_timer : directed + randomized bench against an     |
// |                           integer-seconds reference model.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_game_countdown_timer;

  logic       basys_clk = 1'b0;
  logic       rst_n     = 1'b1;
  logic       slow_clk  = 1'b1;
  logic       load      = 1'b0;
  logic [6:0] load_value = 7'd0;
  logic       start     = 1'b0;
  logic       pause     = 1'b0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       expired;
  logic       time_up;

  int n_checks = 0;
  int n_passed = 0;

  // Reference model: plain seconds count plus a coarse mode.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_cnt;
  int m_mode;
  bit m_prev;
  bit m_exp;

  game_countdown_timer dut (
    .basys_clk  (basys_clk),
    .rst_n      (rst_n),
    .slow_clk   (slow_clk),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .tens       (tens),
    .ones       (ones),
    .running    (running),
    .expired    (expired),
    .time_up    (time_up)
  );

  always #5 basys_clk = ~basys_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cnt  = 60;
    m_mode = M_IDLE;
    m_prev = 1'b1;
    m_exp  = 1'b0;
  endtask

  task automatic model_update();
    bit tk;
    tk     = slow_clk && !m_prev;
    m_prev = slow_clk;
    m_exp  = 1'b0;
    if (load) begin
      m_cnt  = (int'(load_value) > 99) ? 99 : int'(load_value);
      m_mode = M_IDLE;
    end else if (start && m_mode == M_IDLE) begin
      if (m_cnt == 0) begin
        m_mode = M_DONE;
        m_exp  = 1'b1;
      end else begin
        m_mode = M_RUN;
      end
    end else if (start && m_mode == M_PAUSED) begin
      m_mode = M_RUN;
    end else if (pause && m_mode == M_RUN) begin
      m_mode = M_PAUSED;
    end else if (tk && m_mode == M_RUN) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_mode = M_DONE;
        m_exp  = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("tens",    8'(tens),    8'(m_cnt / 10));
    chk("ones",    8'(ones),    8'(m_cnt % 10));
    chk("running", 8'(running), 8'(m_mode == M_RUN));
    chk("expired", 8'(expired), 8'(m_exp));
    chk("time_up", 8'(time_up), 8'(m_mode == M_DONE));
  endtask

  task automatic step(input bit l, input logic [6:0] lv, input bit s, input bit p, input bit sc);
    @(negedge basys_clk);
    load       = l;
    load_value = lv;
    start      = s;
    pause      = p;
    slow_clk   = sc;
    @(posedge basys_clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic sc_tick();
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge basys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_tens", 8'(tens), 8'd6);
    chk("rst_ones", 8'(ones), 8'd0);
    @(negedge basys_clk);
    load     = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    slow_clk = 1'b1;
    @(posedge basys_clk);
    #1;
    check_all();
    @(negedge basys_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #22;
    check_all();
    @(negedge basys_clk);
    rst_n = 1'b1;

    // Held-high slow_clk after reset must not decrement.
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
    chk("no_false_tick", 8'(tens * 10 + ones), 8'd60);
    async_reset();

    // Basic countdown with falling edges in between.
    step(1'b1, 7'd25, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      sc_tick();
      step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    end
    chk("basic_22", 8'(tens * 10 + ones), 8'd22);

    // Borrow.
    step(1'b1, 7'd10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    sc_tick();
    chk("borrow_09", 8'(tens * 10 + ones), 8'd9);

    // Expiry, then ticks in DONE.
    step(1'b1, 7'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    sc_tick();
    sc_tick();
    repeat (3) sc_tick();
    chk("expiry_hold", 8'(tens * 10 + ones), 8'd0);
    chk("expiry_tu",   8'(time_up), 8'd1);

    // Pause colliding with a tick, ticks while paused, resume.
    step(1'b1, 7'd15, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    sc_tick();
    sc_tick();
    chk("paused_15", 8'(tens * 10 + ones), 8'd15);
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    sc_tick();
    chk("resume_14", 8'(tens * 10 + ones), 8'd14);

    // Clamp, abort, load-beats-start, start at zero.
    step(1'b1, 7'd120, 1'b0, 1'b0, 1'b0);
    chk("clamp_99", 8'(tens * 10 + ones), 8'd99);
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    sc_tick();
    step(1'b1, 7'd5, 1'b1, 1'b0, 1'b0);
    chk("load_wins", 8'(running), 8'd0);
    step(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    chk("zero_start_exp", 8'(expired), 8'd1);
    step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional mid-operation resets.
    for (int i = 0; i < 4000; i++) begin
      bit         l, s, p, sc;
      logic [6:0] lv;
      l  = ($urandom_range(99) < 3);
      s  = ($urandom_range(99) < 8);
      p  = ($urandom_range(99) < 4);
      sc = ($urandom_range(3) == 0) ? ~slow_clk : slow_clk;
      lv = ($urandom_range(1) == 0) ? 7'($urandom_range(5)) : 7'($urandom_range(127));
      step(l, lv, s, p, sc);
      if (i % 1000 == 999) async_reset();
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
